vdc_charfetch: RTL

- Per-scanline character/bitmap fetch stage, directly upstream of the pixel/attribute renderer.
- On each new visible line, reads one pattern byte per displayed column from VRAM and fills the ring-buffered `charbuf` that the renderer consumes.
- Flow-controlled against the renderer's current column so it never overwrites an unconsumed entry.
- Sits between the row-buffer fetch logic (`scrnbuf`/`attrbuf`, `dispaddr`) and the VRAM arbiter.

---
 rtl/vdc_charfetch_pkg.sv | 30 +++
 rtl/vdc_charfetch_if.sv | 18 +
 rtl/vdc_charfetch_addr.sv | 43 ++++
 rtl/vdc_charfetch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vdc_charfetch_pkg.sv
// -----------------------------------------------------------------------------
// vdc_pkg
// Shared types and constants for the VDC character/bitmap fetch stage.
//   fetch_state_t : fetch FSM states (IDLE / REQ / DONE)
//   CELL16_SHIFT  : line-select width for 16-byte character cells
//   CELL32_SHIFT  : line-select width for 32-byte character cells
//   CELL16_MAX_CTV: largest reg_ctv value that still uses 16-byte cells
//   CHARSET_ALT_BIT: attribute bit selecting the alternate character set
//   ring_dist()   : 8-bit distance between fetch index and renderer column
// -----------------------------------------------------------------------------
package vdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int          CELL16_SHIFT    = 4;
  localparam int          CELL32_SHIFT    = 5;
  localparam int          CHARSET_ALT_BIT = 7;
  localparam logic [4:0]  CELL16_MAX_CTV  = 5'd15;

  // Entries fetched but not yet consumed; wraps naturally at 256.
  function automatic logic [7:0] ring_dist(input logic [7:0] wr_idx,
                                           input logic [7:0] rd_idx);
    return wr_idx - rd_idx;
  endfunction

endpackage

// File: rtl/vdc_charfetch_if.sv
// -----------------------------------------------------------------------------
// vdc_charfetch_if
// VRAM read port between the character fetch stage and the VRAM arbiter.
//   ram_req  : read request (fetch -> arbiter)
//   ram_addr : read address, stable while ram_req is high
//   ram_ack  : read completes, ram_data valid this cycle (arbiter -> fetch)
//   ram_data : read data
// Modports: master = fetch stage, slave = arbiter.
// -----------------------------------------------------------------------------
interface vdc_charfetch_if;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic        ram_ack;
  logic [7:0]  ram_data;

  modport master (output ram_req, output ram_addr, input ram_ack, input ram_data);
  modport slave  (input ram_req, input ram_addr, output ram_ack, output ram_data);
endinterface

// File: rtl/vdc_charfetch_addr.sv
// -----------------------------------------------------------------------------
// vdc_charfetch_addr
// Pure combinational VRAM address former for the character fetch stage.
//   bitmap   : 1 = bitmap mode (dispaddr + fidx), 0 = text mode
//   reg_cb   : character base
//   reg_ctv  : character total vertical (>15 selects 32-byte cells)
//   sc, alt  : screen code and alternate-charset select of the column
//   line     : current character line
//   dispaddr : bitmap address of the current line
//   fidx     : column being fetched
//   addr     : resulting VRAM address
// -----------------------------------------------------------------------------
module vdc_charfetch_addr
  import vdc_pkg::*;
(
  input  logic        bitmap,
  input  logic [2:0]  reg_cb,
  input  logic [4:0]  reg_ctv,
  input  logic [7:0]  sc,
  input  logic        alt,
  input  logic [4:0]  line,
  input  logic [15:0] dispaddr,
  input  logic [7:0]  fidx,
  output logic [15:0] addr
);

  logic [15:0] addr16;
  logic [15:0] addr32;

  always_comb begin
    // 16-byte cells: {cb[2:0], alt, sc, line[3:0]}; 32-byte cells drop cb[0]
    // to make room for the fifth line bit.
    addr16 = (16'({reg_cb, alt, sc}) << CELL16_SHIFT) | 16'(line[3:0]);
    addr32 = (16'({reg_cb[2:1], alt, sc}) << CELL32_SHIFT) | 16'(line);
    if (bitmap)
      addr = dispaddr + 16'(fidx);
    else if (reg_ctv > CELL16_MAX_CTV)
      addr = addr32;
    else
      addr = addr16;
  end

endmodule

// File: rtl/vdc_charfetch.sv
// -----------------------------------------------------------------------------
// vdc_charfetch
// Per-scanline character/bitmap fetch stage. On each visible line it reads one
// pattern byte per displayed column from VRAM into the charbuf ring consumed by
// the renderer, stalling whenever the ring holds C_LATCH_WIDTH unconsumed
// entries ahead of vcol.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   enable1, fetchLine  : line start, qualified by the clock enable
//   reg_text, reg_atr, reg_cb, reg_ctv, reg_cdv, reg_hd : mode registers
//   line, rowbuf, scrnbuf, attrbuf, dispaddr : current row/line context
//   vcol                : column the renderer is consuming
//   ram                 : VRAM read port (master side)
//   charbuf             : pattern ring, column n at index n % C_LATCH_WIDTH
//   busy                : fetch in progress
//   overrun             : one-cycle pulse when a line restarts mid-fetch
// Optional (macro VDC_CHARFETCH_STATS_EN):
//   stall_cnt           : saturating ring-full stall cycles, cleared per line
//   late_cnt            : saturating overrun count since reset
// -----------------------------------------------------------------------------
module vdc_charfetch
  import vdc_pkg::*;
#(
  parameter int S_LATCH_WIDTH = 82,
  parameter int C_LATCH_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable1,
  input  logic        fetchLine,
  input  logic        reg_text,
  input  logic        reg_atr,
  input  logic [2:0]  reg_cb,
  input  logic [4:0]  reg_ctv,
  input  logic [4:0]  reg_cdv,
  input  logic [7:0]  reg_hd,
  input  logic [4:0]  line,
  input  logic        rowbuf,
  input  logic [7:0]  scrnbuf [2][S_LATCH_WIDTH],
  input  logic [7:0]  attrbuf [2][S_LATCH_WIDTH],
  input  logic [15:0] dispaddr,
  input  logic [7:0]  vcol,
  vdc_charfetch_if.master ram,
  output logic [7:0]  charbuf [C_LATCH_WIDTH],
  output logic        busy,
  output logic        overrun
`ifdef VDC_CHARFETCH_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [7:0]  late_cnt
`endif
);

  localparam int         CW    = $clog2(C_LATCH_WIDTH);
  localparam int         SW    = $clog2(S_LATCH_WIDTH);
  localparam logic [7:0] S_LIM = 8'(S_LATCH_WIDTH);
  localparam logic [7:0] C_LIM = 8'(C_LATCH_WIDTH);

  fetch_state_t state, state_nxt;
  logic [7:0]   fidx;
  logic [7:0]   limit;
  logic [SW-1:0] sidx;
  logic         fetch_go, skip_line, ring_full, have_work, ack_ok;
  logic         ram_req_c;
  logic [7:0]   sc;
  logic         alt;
  logic [15:0]  addr;

  assign fetch_go  = fetchLine & enable1;
  assign limit     = (reg_hd > S_LIM) ? S_LIM : reg_hd;
  assign skip_line = (line > reg_cdv) || (reg_hd == 8'd0);
  assign ring_full = ring_dist(fidx, vcol) >= C_LIM;
  assign have_work = fidx < limit;
  assign ack_ok    = ram.ram_ack & ram_req_c;

  // Only index the row buffers with an in-range column.
  assign sidx = have_work ? fidx[SW-1:0] : '0;
  assign sc   = scrnbuf[rowbuf][sidx];
  assign alt  = reg_atr & attrbuf[rowbuf][sidx][CHARSET_ALT_BIT];

  vdc_charfetch_addr u_addr (
    .bitmap   (reg_text),
    .reg_cb   (reg_cb),
    .reg_ctv  (reg_ctv),
    .sc       (sc),
    .alt      (alt),
    .line     (line),
    .dispaddr (dispaddr),
    .fidx     (fidx),
    .addr     (addr)
  );

  assign ram.ram_req  = ram_req_c;
  assign ram.ram_addr = ram_req_c ? addr : 16'h0000;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (fetch_go) state_nxt = skip_line ? DONE : REQ;
      DONE: state_nxt = fetch_go ? (skip_line ? DONE : REQ) : IDLE;
      REQ: begin
        // A restart stays in REQ; otherwise finish once the last column lands
        // or the limit has dropped below the current index.
        if (fetch_go)                                   state_nxt = REQ;
        else if (ack_ok && ((fidx + 8'd1) >= limit))    state_nxt = DONE;
        else if (!have_work)                            state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ram_req_c = 1'b0;
    busy      = 1'b0;
    if (state == REQ) begin
      busy      = 1'b1;
      ram_req_c = have_work & ~ring_full;
    end
  end

  // Fetch index, ring storage and overrun pulse. A restart wins over a
  // coincident ack, so that ack's data is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fidx    <= 8'd0;
      overrun <= 1'b0;
      // NOTE: charbuf is a small register file the renderer reads directly, so
      // it is reset to a known all-zero state rather than left undefined.
      for (int i = 0; i < C_LATCH_WIDTH; i++) charbuf[i] <= 8'h00;
    end else begin
      overrun <= 1'b0;
      if (fetch_go) begin
        fidx    <= 8'd0;
        overrun <= (state == REQ);
      end else if (ack_ok) begin
        charbuf[fidx[CW-1:0]] <= ram.ram_data;
        fidx                  <= fidx + 8'd1;
      end
    end
  end

`ifdef VDC_CHARFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      late_cnt  <= 8'd0;
    end else begin
      if (fetch_go)
        stall_cnt <= 16'd0;
      else if ((state == REQ) && have_work && ring_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (overrun && (late_cnt != 8'hFF))
        late_cnt <= late_cnt + 8'd1;
    end
  end
`else
  // Statistics counters are not built in the default configuration.
`endif

endmodule
